uint_to_oh_queue: RTL and testbench

- Binary-to-one-hot decoder with ready/valid handshakes on both sides; the inverse of the one-hot-to-binary encoder used in our arbiter and select paths.
- Accepts a binary index, stores its one-hot decode in a 2-entry buffer, and presents it downstream with an out-of-range error flag.
- Keeps a saturating count of good decodes delivered.
- Sits between index producers (arbiter grant encoders, address slicers) and one-hot consumers (mux selects, per-lane enables).

---
 rtl/uint_to_oh_queue.sv | 108 ++++++++++
 tb/tb_uint_to_oh_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uint_to_oh_queue.sv
// Binary index to one-hot decoder behind a 2-entry ready/valid buffer.
// Tracks a saturating count of good decodes delivered downstream.
module uint_to_oh_queue #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [$clog2(N)-1:0] io_in_bits,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [N-1:0]         io_out_bits,
  output logic                 io_out_err,
  output logic [CNT_W-1:0]     io_count
);

  localparam int W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Entry layout: bit N is the out-of-range flag, bits N-1:0 the one-hot decode.
  function automatic logic [N:0] decode(input logic [W-1:0] idx);
    logic [N:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[i] = (int'(idx) == i);
    end
    r[N] = (int'(idx) >= N);
    return r;
  endfunction

  logic             v0_r, v1_r;
  logic [N:0]       head_r, tail_r;
  logic [CNT_W-1:0] count_r;

  logic             v0_s, v1_s;
  logic [N:0]       head_s, tail_s, new_s;
  logic [CNT_W-1:0] count_s;
  logic             enq_s, deq_s;

  assign enq_s = io_in_valid & ~v1_r;
  assign deq_s = v0_r & io_out_ready;
  assign new_s = decode(io_in_bits);

  // Next-state for the buffer slots and the delivered counter.
  always_comb begin
    v0_s    = v0_r;
    v1_s    = v1_r;
    head_s  = head_r;
    tail_s  = tail_r;
    count_s = count_r;
    case ({enq_s, deq_s})
      2'b10: begin
        if (!v0_r) begin
          head_s = new_s;
          v0_s   = 1'b1;
        end else begin
          tail_s = new_s;
          v1_s   = 1'b1;
        end
      end
      2'b01: begin
        // Empty tail slot is kept zero, so the head clears when nothing follows.
        head_s = tail_r;
        v0_s   = v1_r;
        tail_s = '0;
        v1_s   = 1'b0;
      end
      2'b11: begin
        head_s = new_s;
      end
      default: begin
        head_s = head_r;
      end
    endcase
    if (deq_s && !head_r[N] && (count_r != CNT_MAX)) begin
      count_s = count_r + CNT_ONE;
    end else begin
      count_s = count_r;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_r    <= 1'b0;
      v1_r    <= 1'b0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      v0_r    <= v0_s;
      v1_r    <= v1_s;
      head_r  <= head_s;
      tail_r  <= tail_s;
      count_r <= count_s;
    end
  end

  assign io_in_ready  = ~v1_r;
  assign io_out_valid = v0_r;
  assign io_out_bits  = head_r[N-1:0] & {N{v0_r}};
  assign io_out_err   = head_r[N] & v0_r;
  assign io_count     = count_r;

endmodule

// File: tb/tb_uint_to_oh_queue.sv
// Bench for uint_to_oh_queue: directed scenarios on N=4 and N=5/CNT_W=4 instances,
// then random traffic against a queue-based reference model.
module tb_uint_to_oh_queue;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [1:0]  a_in_bits = 2'd0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [3:0]  a_out_bits;
  logic        a_out_err;
  logic [15:0] a_count;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [2:0]  b_in_bits = 3'd0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [4:0]  b_out_bits;
  logic        b_out_err;
  logic [3:0]  b_count;

  int checks = 0;
  int errors = 0;

  uint_to_oh_queue #(.N(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .io_in_valid(a_in_valid), .io_in_ready(a_in_ready), .io_in_bits(a_in_bits),
    .io_out_valid(a_out_valid), .io_out_ready(a_out_ready), .io_out_bits(a_out_bits),
    .io_out_err(a_out_err), .io_count(a_count)
  );

  uint_to_oh_queue #(.N(5), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .io_in_valid(b_in_valid), .io_in_ready(b_in_ready), .io_in_bits(b_in_bits),
    .io_out_valid(b_out_valid), .io_out_ready(b_out_ready), .io_out_bits(b_out_bits),
    .io_out_err(b_out_err), .io_count(b_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_oh(input int idx, input int n);
    if (idx < n) return 5'(1 << idx);
    else return 5'd0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_bits = 2'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_bits = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_bits !== 4'b0000) begin errors++; $display("FAIL rst_bits got %b want 0000", a_out_bits); end
    checks++; if (a_out_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", a_out_err); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", a_in_ready); end
    checks++; if (a_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", a_count); end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %b want 0", b_out_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    a_in_valid = 1'b1; a_in_bits = 2'd2; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", a_out_valid); end
    checks++; if (a_out_bits !== 4'b0100) begin errors++; $display("FAIL single_bits got %b want 0100", a_out_bits); end
    checks++; if (a_out_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", a_out_err); end
    @(negedge clk);
    checks++; if (a_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", a_count); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_bits = 2'd0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", a_in_ready); end
    a_in_bits = 2'd3;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", a_in_ready); end
    checks++; if (a_out_bits !== 4'b0001) begin errors++; $display("FAIL bp_head got %b want 0001", a_out_bits); end
    a_in_bits = 2'd1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b want 0", a_in_ready); end
    checks++; if (a_out_bits !== 4'b0001) begin errors++; $display("FAIL bp_hold got %b want 0001", a_out_bits); end
    a_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_bits !== 4'b1000) begin errors++; $display("FAIL bp_second got %b want 1000", a_out_bits); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b want 1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_bits !== 4'b0010) begin errors++; $display("FAIL bp_third got %b want 0010", a_out_bits); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", a_out_valid); end
    checks++; if (a_count !== 16'd3) begin errors++; $display("FAIL bp_count got %0d want 3", a_count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    do_reset();
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_bits = 2'(i);
      @(negedge clk);
      e = 4'(1 << i);
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, a_in_ready); end
      checks++; if (a_out_valid !== 1'b1 || a_out_bits !== e) begin
        errors++; $display("FAIL b2b_bits[%0d] got v=%b %b want v=1 %b", i, a_out_valid, a_out_bits, e); end
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", a_count); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_bits = 3'd6;
    @(negedge clk);
    checks++; if (b_out_valid !== 1'b1 || b_out_bits !== 5'b00000 || b_out_err !== 1'b1) begin
      errors++; $display("FAIL oor_first got v=%b %b err=%b want v=1 00000 err=1", b_out_valid, b_out_bits, b_out_err); end
    b_in_bits = 3'd4;
    @(negedge clk);
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    checks++; if (b_in_ready !== 1'b0 || b_out_err !== 1'b1) begin
      errors++; $display("FAIL oor_hold got ready=%b err=%b want 0/1", b_in_ready, b_out_err); end
    @(negedge clk);
    checks++; if (b_out_bits !== 5'b10000 || b_out_err !== 1'b0) begin
      errors++; $display("FAIL oor_second got %b err=%b want 10000 err=0", b_out_bits, b_out_err); end
    @(negedge clk);
    checks++; if (b_count !== 4'd1) begin errors++; $display("FAIL oor_count got %0d want 1", b_count); end
  endtask

  task automatic test_saturation();
    int exp;
    do_reset();
    b_out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      exp = (i > 1) ? i - 1 : 0;
      if (exp > 15) exp = 15;
      checks++; if (b_count !== 4'(exp)) begin errors++; $display("FAIL sat_count[%0d] got %0d want %0d", i, b_count, exp); end
      b_in_valid = (i < 20);
      b_in_bits = 3'(i % 5);
      @(negedge clk);
    end
    checks++; if (b_count !== 4'd15) begin errors++; $display("FAIL sat_final got %0d want 15", b_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_bits = 2'd1;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_bits = 2'd2;
    @(negedge clk);
    a_in_bits = 2'd3;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_count !== 16'd1) begin
      errors++; $display("FAIL ar_pre got v=%b r=%b c=%0d want 1/0/1", a_out_valid, a_in_ready, a_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_bits !== 4'b0000) begin errors++; $display("FAIL ar_bits got %b want 0000", a_out_bits); end
    checks++; if (a_count !== 16'd0) begin errors++; $display("FAIL ar_count got %0d want 0", a_count); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", a_in_ready); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int qa[$];
    int qb[$];
    int cnt_a, cnt_b;
    logic [4:0] oh;
    logic ev, ee;
    logic [3:0] eba;
    logic [4:0] ebb;
    bit fin, fout;
    do_reset();
    cnt_a = 0; cnt_b = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ev = (qa.size() > 0);
      oh = ev ? ref_oh(qa[0], 4) : 5'd0;
      eba = oh[3:0];
      checks++; if (a_out_valid !== ev || a_in_ready !== (qa.size() < 2) || a_out_bits !== eba || a_out_err !== 1'b0) begin
        errors++; $display("FAIL rnd_a[%0d] got v=%b r=%b %b e=%b want v=%b r=%b %b e=0", cyc,
          a_out_valid, a_in_ready, a_out_bits, a_out_err, ev, (qa.size() < 2), eba); end
      checks++; if (a_count !== 16'(cnt_a)) begin errors++; $display("FAIL rnd_a_count[%0d] got %0d want %0d", cyc, a_count, cnt_a); end
      ev = (qb.size() > 0);
      ebb = ev ? ref_oh(qb[0], 5) : 5'd0;
      ee = ev && (qb[0] >= 5);
      checks++; if (b_out_valid !== ev || b_in_ready !== (qb.size() < 2) || b_out_bits !== ebb || b_out_err !== ee) begin
        errors++; $display("FAIL rnd_b[%0d] got v=%b r=%b %b e=%b want v=%b r=%b %b e=%b", cyc,
          b_out_valid, b_in_ready, b_out_bits, b_out_err, ev, (qb.size() < 2), ebb, ee); end
      checks++; if (b_count !== 4'(cnt_b)) begin errors++; $display("FAIL rnd_b_count[%0d] got %0d want %0d", cyc, b_count, cnt_b); end
      checks++; if ($countones(b_out_bits) != ((b_out_valid && !b_out_err) ? 1 : 0)) begin
        errors++; $display("FAIL rnd_b_popcount[%0d] got %b want popcount %0d", cyc, b_out_bits, (b_out_valid && !b_out_err) ? 1 : 0); end
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_bits   = 2'($urandom_range(0, 3));
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_bits   = 3'($urandom_range(0, 7));
      b_out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      fin = a_in_valid && (qa.size() < 2);
      fout = a_out_ready && (qa.size() > 0);
      if (fout) begin
        if (qa[0] < 4 && cnt_a < 65535) cnt_a++;
        void'(qa.pop_front());
      end
      if (fin) qa.push_back(int'(a_in_bits));
      fin = b_in_valid && (qb.size() < 2);
      fout = b_out_ready && (qb.size() > 0);
      if (fout) begin
        if (qb[0] < 5 && cnt_b < 15) cnt_b++;
        void'(qb.pop_front());
      end
      if (fin) qb.push_back(int'(b_in_bits));
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
